latch_bank_wr_sched: RTL and testbench
======================================

// Module: latch_bank_wr_sched
// PURPOSE
//  Write scheduler for a shared bank of DEPTH level-sensitive d_latch entries.
//  - Arbitrates NREQ requesters round-robin.
//  - Sequences one write at a time: d setup, enable pulse, d hold.
//  - Keeps latch d stable around every en edge.
//  - Sits between the requesters and the latch bank's d/en pins.
// PARAMETERS
//  NREQ      4  number of requesters (>=2)
//  WIDTH     8  data width of each latch entry
//  DEPTH     4  number of latch entries in the bank
//  AW        2  address width; must satisfy 2**AW >= DEPTH
//  OPEN_CYC  1  cycles lat_en is held high per write (>=1)
// PORTS
//  clk       in   1           system clock, rising edge
//  rst       in   1           synchronous reset, active-high
//  req       in   NREQ        per-requester write request, level
//  addr      in   NREQ*AW     requester i target entry at [i*AW +: AW]
//  wdata     in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  ack       out  NREQ        one-hot, 1-cycle write-complete pulse
//  err       out  1           1-cycle pulse with ack when addr >= DEPTH
//  lat_d     out  WIDTH       shared d bus to all latch entries
//  lat_en    out  DEPTH       one-hot latch enables; all-zero when idle
//  busy      out  1           high in every state except IDLE
//  grant_id  out  clog2(NREQ) index of the requester being serviced
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (sync, rst=1 at a clk edge) from any state:
//      state=IDLE; ack=0; err=0; lat_en=0; lat_d=0; busy=0; grant_id=0; rr_ptr=0.
//  - Reset mid-write: lat_en is 0 after that edge, no ack is issued, and the target entry content is unspecified.
//  - FSM states: IDLE -> SETUP -> OPEN (OPEN_CYC cycles) -> CLOSE -> IDLE.
//  - IDLE:
//      If any req=1, grant the first set req at or after rr_ptr, wrapping from NREQ-1 to 0.
//      At that edge: capture addr/wdata into internal regs, set grant_id, set rr_ptr=(grant+1)%NREQ, go to SETUP.
//  - SETUP: lat_d=captured data; lat_en=0.
//  - OPEN: lat_en[addr]=1 for exactly OPEN_CYC cycles; lat_d unchanged.
//    If addr >= DEPTH, lat_en stays 0 and err is set in CLOSE.
//  - CLOSE: lat_en=0; lat_d held; ack[grant_id]=1 (and err if flagged) for this one cycle; next state IDLE.
//  - lat_d changes only on the edge entering SETUP, so d is stable one cycle before and after every en edge.
//  - Write latency: SETUP one cycle after the granting edge.
//    ack = 2+OPEN_CYC cycles after the grant edge.
//    Throughput: one write per 3+OPEN_CYC cycles.
//  - Handshake:
//      Requester holds req/addr/wdata until it sees ack, and drops req on the edge that ends the ack cycle.
//      Once granted, a write always completes, even if req drops early.
//      addr/wdata changes after the grant are ignored.
//  - Simultaneous requests: exactly one grant per IDLE. The others wait, and nothing is starved.
// CONFIGURATION
//  LSCH_FIXED_PRIO_EN
//    Defined: fixed priority, lowest index wins; rr_ptr is removed.
//    Undefined (default): round-robin as above.
//    The port list is identical in both builds.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, busy=0. Release, no req -> lat_en stays 0.
//  2. req[1]=1, addr1=2, wdata1=8'hA5, OPEN_CYC=1:
//     - lat_d=A5 in SETUP.
//     - lat_en=4'b0100 for 1 cycle.
//     - ack=4'b0010 3 cycles after the grant; err=0.
//  3. req=4'b1111 held, each requester dropping its req after its ack:
//     - grants in order 0,1,2,3.
//     - with LSCH_FIXED_PRIO_EN, req re-raised by 0 -> 0 is granted ahead of 3.
//  4. DEPTH=3, addr=3 -> lat_en stays 0 for the whole write; ack and err pulse together.
//  5. rst=1 during OPEN -> lat_en=0 next cycle, no ack, state IDLE.
//     The next request completes normally.
//  6. OPEN_CYC=3 -> lat_en high exactly 3 cycles. lat_d is constant from SETUP through CLOSE.

Source files
------------

// File: rtl/latch_bank_wr_sched.sv
// Round-robin write scheduler for a bank of d_latch entries.
// Compile-time option: LSCH_FIXED_PRIO_EN selects lowest-index-wins arbitration.
//
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous reset, active-high
//   req      in  : per-requester write request (level)
//   addr     in  : requester i target entry at [i*AW +: AW]
//   wdata    in  : requester i data at [i*WIDTH +: WIDTH]
//   ack      out : one-hot write-complete pulse, one cycle
//   err      out : pulses with ack when the target is >= DEPTH
//   lat_d    out : shared d bus to the latch bank
//   lat_en   out : one-hot latch enables, zero when idle
//   busy     out : high outside IDLE
//   grant_id out : index of the requester in service
module latch_bank_wr_sched #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int OPEN_CYC = 1,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [WIDTH-1:0]      lat_d,
  output logic [DEPTH-1:0]      lat_en,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OPEN,
    CLOSE
  } state_t;

  state_t           st_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] lat_d_q;
  logic [DEPTH-1:0] lat_en_q;
  logic [NREQ-1:0]  ack_q;
  logic             err_q;
  logic             busy_q;
  logic [GW-1:0]    grant_q;
  logic [CW-1:0]    cnt_q;

  logic             found;
  logic [GW-1:0]    gnt;
  int               gi;
  logic [31:0]      addr_w;
  logic             in_rng;
  logic [DEPTH-1:0] en_dec;

`ifdef LSCH_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        gnt   = GW'(i);
      end
    end
  end
`else
  logic [GW-1:0] rr_q;
  logic [GW-1:0] rr_d;
  int            j;

  // Search starts at rr_q and wraps, so the first hit is the RR winner.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        gnt   = GW'(j);
      end
    end
  end

  assign rr_d = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
`endif

  assign gi     = int'(gnt);
  assign addr_w = 32'(addr_q);
  assign in_rng = addr_w < DEPTH;

  always_comb begin
    en_dec = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (in_rng && addr_w == e) en_dec[e] = 1'b1;
    end
  end

  // lat_d is loaded only on the grant edge, so d is stable
  // a full cycle on each side of every en edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      cnt_q    <= '0;
`ifndef LSCH_FIXED_PRIO_EN
      rr_q     <= '0;
`endif
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (found) begin
            addr_q  <= addr[gi*AW +: AW];
            lat_d_q <= wdata[gi*WIDTH +: WIDTH];
            grant_q <= gnt;
            busy_q  <= 1'b1;
            st_q    <= SETUP;
`ifndef LSCH_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
          end
        end
        SETUP: begin
          lat_en_q <= en_dec;
          cnt_q    <= '0;
          st_q     <= OPEN;
        end
        OPEN: begin
          if (cnt_q == CW'(OPEN_CYC - 1)) begin
            lat_en_q <= '0;
            ack_q    <= NREQ'(1) << grant_q;
            err_q    <= !in_rng;
            st_q     <= CLOSE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CLOSE: begin
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Bench for latch_bank_wr_sched: two instances (DEPTH 4/OPEN 1, DEPTH 3/OPEN 3)
// checked every cycle against a transaction-level model plus literal checks.
module tb_latch_bank_wr_sched;

  logic        clk, rst;
  logic [3:0]  req0, req1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wd0, wd1;
  logic [3:0]  ack0, ack1;
  logic        err0, err1;
  logic [7:0]  lat_d0, lat_d1;
  logic [3:0]  lat_en0;
  logic [2:0]  lat_en1;
  logic        busy0, busy1;
  logic [1:0]  gid0, gid1;

  latch_bank_wr_sched #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2), .OPEN_CYC(1)) u0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr0), .wdata(wd0),
    .ack(ack0), .err(err0), .lat_d(lat_d0), .lat_en(lat_en0),
    .busy(busy0), .grant_id(gid0));

  latch_bank_wr_sched #(.NREQ(4), .WIDTH(8), .DEPTH(3), .AW(2), .OPEN_CYC(3)) u1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr1), .wdata(wd1),
    .ack(ack1), .err(err1), .lat_d(lat_d1), .lat_en(lat_en1),
    .busy(busy1), .grant_id(gid1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Transaction model: position within a write, counted from the grant.
  int OC [2] = '{1, 3};
  int DEP[2] = '{4, 3};
  int mbusy[2], mpos[2], mg[2], maddr[2], mdata[2], mrr[2];
  bit mvalid = 0;

  task automatic model_step(int k, logic [3:0] rq, logic [7:0] ad, logic [31:0] wd);
    int g;
    if (rst) begin
      mbusy[k] = 0; mpos[k] = 0; mg[k] = 0;
      maddr[k] = 0; mdata[k] = 0; mrr[k] = 0;
      mvalid = 1;
    end else if (mbusy[k] != 0) begin
      mpos[k]++;
      if (mpos[k] == 3 + OC[k]) begin
        mbusy[k] = 0;
        mpos[k] = 0;
      end
    end else if (rq != 0) begin
      g = -1;
`ifdef LSCH_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (g < 0 && rq[i]) g = i;
`else
      for (int i = 0; i < 4; i++) begin
        int jj;
        jj = (mrr[k] + i) % 4;
        if (g < 0 && rq[jj]) g = jj;
      end
      mrr[k] = (g + 1) % 4;
`endif
      mg[k] = g;
      maddr[k] = int'(ad[g*2 +: 2]);
      mdata[k] = int'(wd[g*8 +: 8]);
      mbusy[k] = 1;
      mpos[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, req0, addr0, wd0);
    model_step(1, req1, addr1, wd1);
  end

  function automatic int exp_en(int k);
    if (mbusy[k] != 0 && mpos[k] >= 2 && mpos[k] <= 1 + OC[k] && maddr[k] < DEP[k])
      return 1 << maddr[k];
    return 0;
  endfunction

  function automatic int exp_ack(int k);
    return (mbusy[k] != 0 && mpos[k] == 2 + OC[k]) ? (1 << mg[k]) : 0;
  endfunction

  function automatic int exp_err(int k);
    return (mbusy[k] != 0 && mpos[k] == 2 + OC[k] && maddr[k] >= DEP[k]) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m0_ack", 32'(ack0), exp_ack(0));
      chk("m0_err", 32'(err0), exp_err(0));
      chk("m0_en", 32'(lat_en0), exp_en(0));
      chk("m0_d", 32'(lat_d0), mdata[0]);
      chk("m0_busy", 32'(busy0), mbusy[0]);
      chk("m0_gid", 32'(gid0), mg[0]);
      chk("m1_ack", 32'(ack1), exp_ack(1));
      chk("m1_err", 32'(err1), exp_err(1));
      chk("m1_en", 32'(lat_en1), exp_en(1));
      chk("m1_d", 32'(lat_d1), mdata[1]);
      chk("m1_busy", 32'(busy1), mbusy[1]);
      chk("m1_gid", 32'(gid1), mg[1]);
    end
  end

  // Requesters drop req once they see their ack.
  task automatic tick();
    @(negedge clk);
    req0 = req0 & ~ack0;
    req1 = req1 & ~ack1;
  endtask

  task automatic set_req(int i, logic [1:0] a, logic [7:0] d);
    req0[i] = 1'b1; addr0[i*2 +: 2] = a; wd0[i*8 +: 8] = d;
    req1[i] = 1'b1; addr1[i*2 +: 2] = a; wd1[i*8 +: 8] = d;
  endtask

  int en0c, en1c, ack0c, ack1c;
  int gl0[$], gl1[$];
  bit dchk;
  logic [7:0] dexp;

  task automatic wait_done(string nm, int lim);
    bit done;
    done = 0;
    en0c = 0; en1c = 0; ack0c = 0; ack1c = 0;
    for (int i = 0; i < lim && !done; i++) begin
      tick();
      if (lat_en0 != 0) en0c++;
      if (lat_en1 != 0) en1c++;
      if (ack0 != 0) begin ack0c++; gl0.push_back(int'(gid0)); end
      if (ack1 != 0) begin ack1c++; gl1.push_back(int'(gid1)); end
      if (dchk && busy1) chk("t6_latd1", 32'(lat_d1), 32'(dexp));
      if (req0 == 0 && req1 == 0 && !busy0 && !busy1) done = 1;
    end
    if (!done) chk({nm, "_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0;
    addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
    dchk = 0; dexp = 0;
    tick(); tick();
    chk("rst_ack", 32'(ack0), 0);
    chk("rst_en", 32'(lat_en0), 0);
    chk("rst_d", 32'(lat_d0), 0);
    chk("rst_busy", 32'({busy1, busy0}), 0);
    chk("rst_gid", 32'(gid0), 0);
    chk("rst_err", 32'({err1, err0}), 0);
    rst = 0;
    tick(); tick(); tick();
    chk("idle_en", 32'({lat_en1, lat_en0}), 0);
    chk("idle_busy", 32'(busy0), 0);

    // Single write by requester 1 to entry 2.
    set_req(1, 2'd2, 8'hA5);
    tick();
    chk("t2_setup_d", 32'(lat_d0), 32'hA5);
    chk("t2_setup_en", 32'(lat_en0), 0);
    chk("t2_gid", 32'(gid0), 1);
    tick();
    chk("t2_open_en0", 32'(lat_en0), 32'b0100);
    chk("t2_open_en1", 32'(lat_en1), 32'b100);
    tick();
    chk("t2_ack0", 32'(ack0), 32'b0010);
    chk("t2_err0", 32'(err0), 0);
    chk("t2_close_en0", 32'(lat_en0), 0);
    tick(); tick();
    chk("t2_ack1", 32'(ack1), 32'b0010);
    wait_done("t2", 40);

    // Four simultaneous requests after a fresh reset.
    rst = 1; tick(); rst = 0;
    gl0.delete(); gl1.delete();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'h30 + i));
    wait_done("t3", 80);
    chk("t3_n0", 32'(gl0.size()), 4);
    chk("t3_n1", 32'(gl1.size()), 4);
    for (int i = 0; i < 4 && i < gl0.size() && i < gl1.size(); i++) begin
      chk("t3_ord0", 32'(gl0[i]), 32'(i));
      chk("t3_ord1", 32'(gl1[i]), 32'(i));
    end

    // Out-of-range entry on the DEPTH=3 instance.
    set_req(2, 2'd3, 8'h5A);
    wait_done("t4", 40);
    chk("t4_en1", 32'(en1c), 0);
    chk("t4_en0", 32'(en0c), 1);
    chk("t4_ack1", 32'(ack1c), 1);

    // Reset while OPEN; the held request is serviced afterwards.
    set_req(0, 2'd1, 8'h77);
    tick(); tick();
    chk("t5_open_en0", 32'(lat_en0), 32'b0010);
    rst = 1;
    tick();
    chk("t5_rst_en", 32'({lat_en1, lat_en0}), 0);
    chk("t5_rst_ack", 32'({ack1, ack0}), 0);
    chk("t5_rst_busy", 32'({busy1, busy0}), 0);
    rst = 0;
    wait_done("t5", 40);
    chk("t5_ack0", 32'(ack0c), 1);
    chk("t5_ack1", 32'(ack1c), 1);

    // OPEN_CYC=3: enable width and d stability.
    dchk = 1; dexp = 8'hC3;
    set_req(3, 2'd1, 8'hC3);
    wait_done("t6", 40);
    dchk = 0;
    chk("t6_en1_cyc", 32'(en1c), 3);
    chk("t6_en0_cyc", 32'(en0c), 1);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
